// File: rtl/imem_responder.sv
// ============================================================================
// Module   : imem_responder
// Brief    : Instruction memory fetch responder with fixed latency and preload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int          c_idx_w = $clog2(DEPTH);
    localparam logic [32:0] c_span  = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  c_wait  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [31:0]         r_addr;
    logic [31:0]         r_rdata;
    logic [31:0]         r_mem [DEPTH];

    logic [31:0]         w_req_off;
    logic [c_idx_w-1:0]  w_req_idx;
    logic                w_req_fault;
    logic                w_accept;

    function automatic logic addr_fault(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ({1'b0, off} >= c_span);
    endfunction

    assign w_req_off   = req_addr - BASE_ADDR;
    assign w_req_idx   = w_req_off[c_idx_w+1:2];
    assign w_req_fault = addr_fault(req_addr);
    assign w_accept    = req_valid && (r_state == S_IDLE);

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = rsp_valid ? r_rdata : 32'h0;
    assign rsp_err   = rsp_valid && addr_fault(r_addr);

    // Preload port; reads in the FSM sample the pre-write value on a shared edge.
    always_ff @(posedge clk) begin
        if (rst && ld_en && (ld_addr < 32'(DEPTH))) begin
            r_mem[ld_addr[c_idx_w-1:0]] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'h0;
            r_rdata <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_rdata <= w_req_fault ? 32'h0 : r_mem[w_req_idx];
                        if (LATENCY == 1) begin
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= c_wait;
                        end
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                        r_rdata <= 32'h0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
// ============================================================================
// Module   : tb_imem_responder
// Brief    : Directed self-checking bench for imem_responder (LATENCY 2 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        rsp_ready;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    logic        req_ready,   rsp_valid,   rsp_err;
    logic [31:0] rsp_rdata;
    logic        u1_req_ready, u1_rsp_valid, u1_rsp_err;
    logic [31:0] u1_rsp_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_responder #(.DEPTH(1024), .LATENCY(1), .BASE_ADDR(32'h8000_0000)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(u1_req_ready), .req_addr(req_addr),
        .rsp_valid(u1_rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(u1_rsp_rdata), .rsp_err(u1_rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // LATENCY=2 fetch: WAIT one cycle, RESP one cycle, IDLE again.
    task automatic fetch2(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e);
        req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0; req_addr = 32'h8000_0000;
        chk({tag, "_wait_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_wait_rdata"}, rsp_rdata, 32'h0);
        tick();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_rdata"}, rsp_rdata, exp_d);
        chk({tag, "_err"},   32'(rsp_err), 32'(exp_e));
        chk({tag, "_busy"},  32'(req_ready), 32'd0);
        tick();
        chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] l1_addr [4];
        logic [31:0] l1_data [4];

        rst = 1'b0; req_valid = 1'b0; req_addr = 32'h0; rsp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
        tick();
        tick();
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err",   32'(rsp_err), 32'd0);
        rst = 1'b1;
        tick();
        chk("rst_ready", 32'(req_ready), 32'd1);

        load(32'd0,    32'h0000_0013);
        load(32'd1,    32'h1111_1111);
        load(32'd2,    32'h2222_2222);
        load(32'd1023, 32'hCAFE_F00D);
        load(32'd1024, 32'h0BAD_0BAD);

        fetch2("w0",      32'h8000_0000, 32'h0000_0013, 1'b0);
        fetch2("w1023",   32'h8000_0FFC, 32'hCAFE_F00D, 1'b0);
        fetch2("misal",   32'h8000_0002, 32'h0, 1'b1);
        fetch2("over",    32'h8000_1000, 32'h0, 1'b1);
        fetch2("under",   32'h7FFF_FFFC, 32'h0, 1'b1);
        fetch2("wrapoff", 32'hFFFF_FFFC, 32'h0, 1'b1);

        // Back-pressure: response held for five cycles, request pending at handshake.
        req_valid = 1'b1; req_addr = 32'h8000_0008; rsp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rdata", rsp_rdata, 32'h2222_2222);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h8000_0000;
        tick();
        req_valid = 1'b0;
        chk("bp_idle_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_valid", 32'(rsp_valid), 32'd0);

        // Preload write on the accepting edge must not disturb the in-flight read.
        req_valid = 1'b1; req_addr = 32'h8000_0004;
        ld_en = 1'b1; ld_addr = 32'd1; ld_data = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0; ld_en = 1'b0;
        tick();
        chk("raw_old_valid", 32'(rsp_valid), 32'd1);
        chk("raw_old_rdata", rsp_rdata, 32'h1111_1111);
        tick();
        fetch2("raw_new", 32'h8000_0004, 32'hDEAD_BEEF, 1'b0);

        // Reset during WAIT drops the response; preload during reset is ignored.
        req_valid = 1'b1; req_addr = 32'h8000_0008;
        tick();
        req_valid = 1'b0;
        rst = 1'b0; ld_en = 1'b1; ld_addr = 32'd0; ld_data = 32'h5555_5555;
        tick();
        rst = 1'b1; ld_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rstwait_valid", 32'(rsp_valid), 32'd0);
            tick();
        end
        fetch2("post_rst_w2", 32'h8000_0008, 32'h2222_2222, 1'b0);
        fetch2("post_rst_w0", 32'h8000_0000, 32'h0000_0013, 1'b0);

        // LATENCY=1 instance: back-to-back requests, one response every two cycles.
        l1_addr[0] = 32'h8000_0000; l1_data[0] = 32'h0000_0013;
        l1_addr[1] = 32'h8000_0004; l1_data[1] = 32'hDEAD_BEEF;
        l1_addr[2] = 32'h8000_0008; l1_data[2] = 32'h2222_2222;
        l1_addr[3] = 32'h8000_0FFC; l1_data[3] = 32'hCAFE_F00D;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr = l1_addr[i];
            tick();
            req_addr = 32'h8000_0002;
            chk("l1_valid", 32'(u1_rsp_valid), 32'd1);
            chk("l1_rdata", u1_rsp_rdata, l1_data[i]);
            chk("l1_err",   32'(u1_rsp_err), 32'd0);
            chk("l1_busy",  32'(u1_req_ready), 32'd0);
            tick();
            chk("l1_gap_valid", 32'(u1_rsp_valid), 32'd0);
            chk("l1_gap_ready", 32'(u1_req_ready), 32'd1);
        end
        req_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
